// File: rtl/setbit_cmp_seq.sv
// Counts set (mode=0) or clear (mode=1) bits of two latched operands, one bit per cycle, then compares the counts.
// Latency WIDTH+1 cycles from the start edge to done; start is ignored while busy and accepted again in the done cycle.
module setbit_cmp_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    cntA,
    output logic [CW-1:0]    cntB,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        CMP   = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic             mode_q;
    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    ca_q, cb_q;
    logic [CW-1:0]    cnt_a_q, cnt_b_q;
    logic             gt_q, lt_q, eq_q, done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COUNT;
            COUNT:   if (idx_q == LAST_IDX) state_d = CMP;
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shadow operands shift right so the bit under test is always bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q <= A;
                        b_sh_q <= B;
                        mode_q <= mode;
                        idx_q  <= '0;
                        ca_q   <= '0;
                        cb_q   <= '0;
                    end
                end
                COUNT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    ca_q   <= ca_q + CW'(a_sh_q[0] ^ mode_q);
                    cb_q   <= cb_q + CW'(b_sh_q[0] ^ mode_q);
                    idx_q  <= idx_q + CW'(1);
                end
                CMP: begin
                    cnt_a_q <= ca_q;
                    cnt_b_q <= cb_q;
                    gt_q    <= (ca_q > cb_q);
                    lt_q    <= (ca_q < cb_q);
                    eq_q    <= (ca_q == cb_q);
                    done_q  <= 1'b1;
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign cntA = cnt_a_q;
    assign cntB = cnt_b_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_setbit_cmp_seq.sv
// Scoreboard bench for setbit_cmp_seq: an 8-bit and a 16-bit instance driven by directed and random operations.
module tb_setbit_cmp_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       start_v = '0;
    logic [1:0]       mode_v  = '0;
    logic [1:0][15:0] a_v     = '0;
    logic [1:0][15:0] b_v     = '0;

    wire  [1:0]      busy_v, done_v, gt_v, lt_v, eq_v;
    wire  [1:0][4:0] ca_v, cb_v;
    logic [3:0]      ca8, cb8;
    logic [4:0]      ca16, cb16;

    assign ca_v[0] = {1'b0, ca8};
    assign cb_v[0] = {1'b0, cb8};
    assign ca_v[1] = ca16;
    assign cb_v[1] = cb16;

    setbit_cmp_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]),
        .A(a_v[0][7:0]), .B(b_v[0][7:0]),
        .busy(busy_v[0]), .done(done_v[0]), .cntA(ca8), .cntB(cb8),
        .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0])
    );

    setbit_cmp_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]),
        .A(a_v[1]), .B(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .cntA(ca16), .cntB(cb16),
        .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1])
    );

    typedef struct {
        int tag;
        int ca;
        int cb;
        int gt;
        int lt;
        int eq;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cur_k[2]  = '{-100, -100};
    int   free_e[2] = '{0, 0};
    int   last_ca[2] = '{0, 0};
    int   last_cb[2] = '{0, 0};
    int   last_gt[2] = '{0, 0};
    int   last_lt[2] = '{0, 0};
    int   last_eq[2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wd(input int d);
        return (d != 0) ? 16 : 8;
    endfunction

    function automatic int ones(input logic [15:0] v, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start edge e is accepted once the previous operation's done cycle has been reached.
    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b, input logic m);
        int   e;
        int   w;
        exp_t x;
        w = wd(d);
        a_v[d] = a;
        b_v[d] = b;
        mode_v[d] = m;
        start_v[d] = 1'b1;
        e = cyc + 1;
        if (e >= free_e[d]) begin
            x.tag = d;
            x.ca  = m ? w - ones(a, w) : ones(a, w);
            x.cb  = m ? w - ones(b, w) : ones(b, w);
            x.gt  = int'(x.ca > x.cb);
            x.lt  = int'(x.ca < x.cb);
            x.eq  = int'(x.ca == x.cb);
            x.cyc = e + w + 1;
            sb.push_back(x);
            cur_k[d]  = e;
            free_e[d] = e + w + 2;
        end
        tick(1);
        start_v[d] = 1'b0;
        a_v[d] = 16'($urandom);
        b_v[d] = 16'($urandom);
        mode_v[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic check_zero(input int d);
        chk($sformatf("rst_busy%0d", d), int'(busy_v[d]), 0);
        chk($sformatf("rst_done%0d", d), int'(done_v[d]), 0);
        chk($sformatf("rst_cntA%0d", d), int'(ca_v[d]), 0);
        chk($sformatf("rst_cntB%0d", d), int'(cb_v[d]), 0);
        chk($sformatf("rst_flags%0d", d), int'({gt_v[d], lt_v[d], eq_v[d]}), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        sb.delete();
        for (int d = 0; d < 2; d++) begin
            cur_k[d] = -100;
            free_e[d] = 0;
            last_ca[d] = 0;
            last_cb[d] = 0;
            last_gt[d] = 0;
            last_lt[d] = 0;
            last_eq[d] = 0;
        end
        tick(2);
        rst = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            tick(1);
            t++;
        end
        chk("drain_timeout", sb.size(), 0);
        tick(2);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy%0d", d), int'(busy_v[d]),
                    int'(cyc >= cur_k[d] && cyc <= cur_k[d] + wd(d)));
                if (done_v[d]) begin
                    chk($sformatf("onehot%0d", d), int'(gt_v[d]) + int'(lt_v[d]) + int'(eq_v[d]), 1);
                    if (sb.size() == 0) begin
                        chk($sformatf("unexpected_done%0d", d), 1, 0);
                    end else begin
                        x = sb.pop_front();
                        chk("done_dut", d, x.tag);
                        chk($sformatf("done_cycle%0d", d), cyc, x.cyc);
                        chk($sformatf("cntA%0d", d), int'(ca_v[d]), x.ca);
                        chk($sformatf("cntB%0d", d), int'(cb_v[d]), x.cb);
                        chk($sformatf("gt%0d", d), int'(gt_v[d]), x.gt);
                        chk($sformatf("lt%0d", d), int'(lt_v[d]), x.lt);
                        chk($sformatf("eq%0d", d), int'(eq_v[d]), x.eq);
                    end
                    last_ca[d] = int'(ca_v[d]);
                    last_cb[d] = int'(cb_v[d]);
                    last_gt[d] = int'(gt_v[d]);
                    last_lt[d] = int'(lt_v[d]);
                    last_eq[d] = int'(eq_v[d]);
                end else begin
                    chk($sformatf("hold_cntA%0d", d), int'(ca_v[d]), last_ca[d]);
                    chk($sformatf("hold_cntB%0d", d), int'(cb_v[d]), last_cb[d]);
                    chk($sformatf("hold_flags%0d", d), int'({gt_v[d], lt_v[d], eq_v[d]}),
                        last_gt[d] * 4 + last_lt[d] * 2 + last_eq[d]);
                end
            end
        end
    end

    initial begin : stimulus
        int d;
        int prev;
        logic [15:0] a;
        logic [15:0] b;
        #1;
        rst = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        tick(3);
        rst = 1'b0;

        issue(0, 16'd64, 16'd31, 1'b0);
        drain();

        issue(0, 16'd21, 16'd129, 1'b0);
        tick(9);
        issue(0, 16'd224, 16'd7, 1'b0);
        drain();

        issue(0, 16'd2, 16'd7, 1'b1);
        tick(2);
        issue(0, 16'd255, 16'd255, 1'b0);
        drain();

        issue(0, 16'd255, 16'd0, 1'b0);
        tick(3);
        do_reset();
        issue(0, 16'd9, 16'd2, 1'b0);
        drain();

        issue(1, 16'hFFFF, 16'h0000, 1'b0);
        drain();
        issue(1, 16'hFFFF, 16'h0000, 1'b1);
        drain();

        issue(0, 16'h0000, 16'h0000, 1'b0);
        tick(9);
        issue(0, 16'h00FF, 16'h00FF, 1'b1);
        tick(9);
        issue(0, 16'h00A5, 16'h00A5, 1'b1);
        drain();
        issue(1, 16'h0000, 16'h0000, 1'b1);
        drain();

        prev = 0;
        for (int i = 0; i < 60; i++) begin
            d = $urandom_range(0, 1);
            if (d != prev) drain();
            prev = d;
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            issue(d, a, b, 1'($urandom_range(0, 1)));
            tick($urandom_range(0, wd(d) + 3));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
